// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digit updates.
// Optional build macro: LZ_BLANK_EN (leading-zero suppression on digits above 0).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_CYC  = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    upd_done,
  output logic                    pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(DIGIT_CYC);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(DIGIT_CYC - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] pend_reg, act_reg, act_nx;
  logic                    wrap, commit;
  logic [NUM_DIGITS-1:0]   dig_n_nx;
  logic [3:0]              bcd_nx;
`ifdef LZ_BLANK_EN
  logic                    lz_blank;
`endif

  // Slot sequencing: cnt runs 0..DIGIT_CYC-1 across SCAN then BLANK.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    if (!en) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SCAN;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        SCAN: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == SCAN_LAST) state_nx = BLANK;
        end
        BLANK: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            state_nx = SCAN;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Commit only at a frame boundary (or immediately while idle) so a frame never mixes values.
  always_comb begin
    wrap   = en && (state == BLANK) && (cnt == SLOT_LAST) && (idx == IDX_LAST);
    commit = pending && ((state == IDLE) || wrap);
    act_nx = commit ? pend_reg : act_reg;
  end

  // Outputs are computed from next-cycle state so the registered outputs line up with state.
  always_comb begin
    dig_n_nx = '1;
    bcd_nx   = 4'hF;
    if (state_nx == SCAN) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_nx == IDX_W'(i)) begin
          dig_n_nx[i] = 1'b0;
          bcd_nx      = act_nx[4*i +: 4];
        end
      end
    end
`ifdef LZ_BLANK_EN
    lz_blank = (idx_nx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_nx) && (act_nx[4*i +: 4] != 4'h0)) lz_blank = 1'b0;
    end
    if ((state_nx == SCAN) && lz_blank) bcd_nx = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      act_reg  <= ALL_BLANK;
      pend_reg <= ALL_BLANK;
      pending  <= 1'b0;
      upd_done <= 1'b0;
      dig_n    <= '1;
      bcd_out  <= 4'hF;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      act_reg  <= act_nx;
      upd_done <= commit;
      dig_n    <= dig_n_nx;
      bcd_out  <= bcd_nx;
      if (load) pend_reg <= digits_in;
      // A load on the commit edge re-arms pending for the next boundary.
      if (load)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DIGIT_CYC=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_n;
  logic        upd_done;
  logic        pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .DIGIT_CYC (DC),
    .BLANK_CYC (BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .digits_in(digits_in),
    .bcd_out  (bcd_out),
    .dig_n    (dig_n),
    .upd_done (upd_done),
    .pending  (pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_digit(input logic [15:0] val, input int d);
    logic [3:0] nib;
`ifdef LZ_BLANK_EN
    logic [15:0] above;
`endif
    nib = val[4*d +: 4];
`ifdef LZ_BLANK_EN
    above = val >> (4*d);
    if (d > 0 && above == 16'h0) nib = 4'hF;
`endif
    return nib;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dig_n"}, 32'(dig_n), 32'h0000000F);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'h0000000F);
    chk({tag, "_upd"}, 32'(upd_done), 32'h0);
    chk({tag, "_pend"}, 32'(pending), 32'h0);
  endtask

  // One full digit slot: 6 scan cycles then 2 blank cycles, optional load mid-slot.
  task automatic slot(input logic [15:0] val, input int d, input logic exp_upd,
                      input int ld_at, input logic [15:0] ld_val);
    logic [3:0] exp_dn;
    exp_dn = ~(4'b0001 << d);
    for (int i = 0; i < DC; i++) begin
      tick();
      load = 1'b0;
      if (i < DC - BC) begin
        chk("scan_dig_n", 32'(dig_n), 32'(exp_dn));
        chk("scan_bcd", 32'(bcd_out), 32'(exp_digit(val, d)));
      end else begin
        chk("blank_dig_n", 32'(dig_n), 32'h0000000F);
        chk("blank_bcd", 32'(bcd_out), 32'h0000000F);
      end
      chk("upd_done", 32'(upd_done), (i == 0) ? 32'(exp_upd) : 32'h0);
      if (i == 0 && exp_upd) chk("commit_pending", 32'(pending), 32'h0);
      if (ld_at >= 0 && i == ld_at + 1) chk("load_pending", 32'(pending), 32'h1);
      if (i == ld_at) begin
        load      = 1'b1;
        digits_in = ld_val;
      end
    end
  endtask

  task automatic frame(input logic [15:0] val, input logic exp_upd);
    for (int d = 0; d < ND; d++) slot(val, d, (d == 0) ? exp_upd : 1'b0, -1, 16'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0;
    #12;
    chk_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load while idle: captured, then committed on the following edge.
    tick();
    load = 1'b1;
    digits_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("idle_load_pend", 32'(pending), 32'h1);
    chk("idle_load_upd", 32'(upd_done), 32'h0);
    tick();
    chk("idle_commit_upd", 32'(upd_done), 32'h1);
    chk("idle_commit_pend", 32'(pending), 32'h0);
    tick();
    chk("idle_upd_clear", 32'(upd_done), 32'h0);
    chk("idle_dig_n", 32'(dig_n), 32'h0000000F);
    chk("idle_bcd", 32'(bcd_out), 32'h0000000F);

    en = 1'b1;
    frame(16'h1234, 1'b0);
    frame(16'h1234, 1'b0);

    // Load mid-frame: the rest of the frame keeps the old value.
    slot(16'h1234, 0, 1'b0, -1, 16'h0);
    slot(16'h1234, 1, 1'b0, 2, 16'h5678);
    slot(16'h1234, 2, 1'b0, -1, 16'h0);
    slot(16'h1234, 3, 1'b0, -1, 16'h0);
    frame(16'h5678, 1'b1);

    // Two loads in one frame: only the latest is ever shown.
    slot(16'h5678, 0, 1'b0, 1, 16'h0042);
    slot(16'h5678, 1, 1'b0, 1, 16'h0099);
    slot(16'h5678, 2, 1'b0, -1, 16'h0);
    slot(16'h5678, 3, 1'b0, -1, 16'h0);
    frame(16'h0099, 1'b1);

    // Drop en during digit 2 scan, then restart from digit 0.
    slot(16'h0099, 0, 1'b0, -1, 16'h0);
    slot(16'h0099, 1, 1'b0, -1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d2_dig_n", 32'(dig_n), 32'h0000000B);
      chk("d2_bcd", 32'(bcd_out), 32'(exp_digit(16'h0099, 2)));
    end
    en = 1'b0;
    tick();
    chk("endrop_dig_n", 32'(dig_n), 32'h0000000F);
    chk("endrop_bcd", 32'(bcd_out), 32'h0000000F);
    tick();
    chk("endrop_hold_dig_n", 32'(dig_n), 32'h0000000F);
    en = 1'b1;
    frame(16'h0099, 1'b0);

    // Async reset mid-scan with a value pending.
    tick();
    load = 1'b1;
    digits_in = 16'h4321;
    tick();
    load = 1'b0;
    chk("prerst_pend", 32'(pending), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("postrst_dig_n", 32'(dig_n), 32'h0000000E);
    chk("postrst_bcd", 32'(bcd_out), 32'h0000000F);
    chk("postrst_pend", 32'(pending), 32'h0);

    // Zero-heavy values exercise leading-zero handling when enabled.
    en = 1'b0;
    load = 1'b1;
    digits_in = 16'h0042;
    tick();
    load = 1'b0;
    chk("lz1_pend", 32'(pending), 32'h1);
    chk("lz1_idle_dig_n", 32'(dig_n), 32'h0000000F);
    tick();
    chk("lz1_upd", 32'(upd_done), 32'h1);
    en = 1'b1;
    frame(16'h0042, 1'b0);
    en = 1'b0;
    load = 1'b1;
    digits_in = 16'h0000;
    tick();
    load = 1'b0;
    tick();
    chk("lz2_upd", 32'(upd_done), 32'h1);
    en = 1'b1;
    frame(16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
